// File: rtl/edn_ep_packer.sv
// Packs successive EDN entropy words into one OutWidth-bit bundle for a local consumer.
// edn_req_o one cycle after req_i, ack_o NumWords cycles later; a finished bundle is held until req_i.
module edn_ep_packer #(
  parameter int unsigned EdnWidth = 32,
  parameter int unsigned OutWidth = 128
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  input  logic                clear_i,
  input  logic                req_i,
  output logic                ack_o,
  output logic [OutWidth-1:0] data_o,
  output logic                fips_o,
  output logic                edn_req_o,
  input  logic                edn_ack_i,
  input  logic [EdnWidth-1:0] edn_bus_i,
  input  logic                edn_fips_i,
  output logic                proto_err_o
);

  localparam int unsigned NumWords = OutWidth / EdnWidth;
  localparam int unsigned CntWidth = (NumWords > 1) ? $clog2(NumWords) : 1;
  localparam logic [CntWidth-1:0] LastIdx = CntWidth'(NumWords - 1);

  if (((OutWidth % EdnWidth) != 0) || (OutWidth < EdnWidth)) begin : g_bad_width
    $error("OutWidth must be a non-zero multiple of EdnWidth");
  end

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FILL  = 2'd1,
    READY = 2'd2
  } state_e;

  state_e                state;
  state_e                state_next;
  logic [CntWidth-1:0]   cnt;
  logic [OutWidth-1:0]   data_q;
  logic                  fips_q;
  logic                  capture;
  logic                  ack;

  always_comb begin
    state_next  = state;
    capture     = 1'b0;
    ack         = 1'b0;
    proto_err_o = 1'b0;
    // A flush swallows everything in its cycle, including a stray EDN word.
    if (clear_i) begin
      state_next = IDLE;
    end else begin
      unique case (state)
        IDLE: begin
          proto_err_o = edn_ack_i;
          if (req_i) state_next = FILL;
        end
        FILL: begin
          if (edn_ack_i) begin
            capture = 1'b1;
            if (cnt == LastIdx) state_next = READY;
          end
        end
        READY: begin
          proto_err_o = edn_ack_i;
          ack         = req_i;
          if (req_i) state_next = IDLE;
        end
        default: state_next = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni || clear_i) begin
      state  <= IDLE;
      cnt    <= '0;
      data_q <= '0;
      fips_q <= 1'b1;
    end else begin
      state <= state_next;
      if (state == IDLE && req_i) begin
        cnt    <= '0;
        data_q <= '0;
        fips_q <= 1'b1;
      end
      if (capture) begin
        for (int unsigned i = 0; i < NumWords; i++) begin
          if (cnt == CntWidth'(i)) data_q[i*EdnWidth +: EdnWidth] <= edn_bus_i;
        end
        fips_q <= fips_q & edn_fips_i;
        cnt    <= cnt + 1'b1;
      end
    end
  end

  assign edn_req_o = (state == FILL);
  assign ack_o     = ack;
  assign data_o    = data_q;
  assign fips_o    = fips_q & ack;

endmodule

// File: tb/tb_edn_ep_packer.sv
// Scoreboard bench for edn_ep_packer: expected bundles queued at stimulus time, checked on ack_o.
module tb_edn_ep_packer;

  logic         clk = 1'b0;
  logic         rst_ni;
  logic         clear_i;
  logic         req_i;
  logic         ack_o;
  logic [127:0] data_o;
  logic         fips_o;
  logic         edn_req_o;
  logic         edn_ack_i;
  logic [31:0]  edn_bus_i;
  logic         edn_fips_i;
  logic         proto_err_o;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int ack_cnt  = 0;
  int last_ack = -1;
  int prev_ack = -1;
  logic [128:0] exp_q[$];

  edn_ep_packer #(.EdnWidth(32), .OutWidth(128)) dut (
    .clk_i       (clk),
    .rst_ni      (rst_ni),
    .clear_i     (clear_i),
    .req_i       (req_i),
    .ack_o       (ack_o),
    .data_o      (data_o),
    .fips_o      (fips_o),
    .edn_req_o   (edn_req_o),
    .edn_ack_i   (edn_ack_i),
    .edn_bus_i   (edn_bus_i),
    .edn_fips_i  (edn_fips_i),
    .proto_err_o (proto_err_o)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  // Every ack must match the oldest queued bundle {fips, data}.
  always @(negedge clk) begin
    if (ack_o === 1'b1) begin
      logic [128:0] e;
      ack_cnt++;
      prev_ack = last_ack;
      last_ack = cyc;
      n_checks++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL unexpected_ack at cycle %0d got data=%h fips=%b required no ack", cyc, data_o, fips_o);
      end else begin
        e = exp_q.pop_front();
        if ({fips_o, data_o} !== e) begin
          n_fail++;
          $display("FAIL bundle got fips=%b data=%h required fips=%b data=%h", fips_o, data_o, e[128], e[127:0]);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic deliver(input logic [127:0] b, input logic [3:0] fv, input int gap);
    for (int i = 0; i < 4; i++) begin
      edn_ack_i  = 1'b1;
      edn_bus_i  = b[i*32 +: 32];
      edn_fips_i = fv[i];
      tick();
      edn_ack_i  = 1'b0;
      if (i < 3) repeat (gap) tick();
    end
  endtask

  task automatic test_reset();
    rst_ni = 1'b0; clear_i = 1'b0; req_i = 1'b0;
    edn_ack_i = 1'b0; edn_bus_i = '0; edn_fips_i = 1'b0;
    repeat (3) tick();
    rst_ni = 1'b1;
    #1;
    n_checks++;
    if ({ack_o, fips_o, edn_req_o, proto_err_o} !== 4'b0000 || data_o !== 128'h0) begin
      n_fail++;
      $display("FAIL reset_outputs got ack=%b fips=%b edn_req=%b perr=%b data=%h required all 0",
               ack_o, fips_o, edn_req_o, proto_err_o, data_o);
    end
  endtask

  task automatic test_basic();
    logic [127:0] b = 128'h44444444_33333333_22222222_11111111;
    int acks0 = ack_cnt;
    exp_q.push_back({1'b1, b});
    req_i = 1'b1;
    tick();
    n_checks++;
    if (edn_req_o !== 1'b1) begin n_fail++; $display("FAIL basic_edn_req_fill got %b required 1", edn_req_o); end
    deliver(b, 4'hF, 0);
    n_checks++;
    if (edn_req_o !== 1'b0 || ack_o !== 1'b1) begin
      n_fail++; $display("FAIL basic_ready got edn_req=%b ack=%b required edn_req=0 ack=1", edn_req_o, ack_o);
    end
    tick();
    req_i = 1'b0;
    repeat (3) tick();
    n_checks++;
    if (ack_cnt - acks0 !== 1) begin n_fail++; $display("FAIL basic_ack_count got %0d required 1", ack_cnt - acks0); end
  endtask

  task automatic test_fips();
    logic [127:0] b1 = 128'h0D0D0D0D_0C0C0C0C_0B0B0B0B_0A0A0A0A;
    logic [127:0] b2 = 128'hF4F4F4F4_F3F3F3F3_F2F2F2F2_F1F1F1F1;
    exp_q.push_back({1'b0, b1});
    req_i = 1'b1;
    tick();
    deliver(b1, 4'b1011, 0);
    n_checks++;
    if (fips_o !== 1'b0) begin n_fail++; $display("FAIL fips_low got %b required 0", fips_o); end
    tick();
    exp_q.push_back({1'b1, b2});
    tick();
    deliver(b2, 4'hF, 0);
    n_checks++;
    if (fips_o !== 1'b1) begin n_fail++; $display("FAIL fips_reinit got %b required 1", fips_o); end
    tick();
    req_i = 1'b0;
    tick();
  endtask

  task automatic test_prefetch(output logic [127:0] held);
    logic [127:0] b = 128'h76543210_FEDCBA98_13579BDF_02468ACE;
    held = b;
    req_i = 1'b1;
    tick();
    req_i = 1'b0;
    deliver(b, 4'hF, 2);
    repeat (10) tick();
    n_checks++;
    if (ack_o !== 1'b0 || edn_req_o !== 1'b0) begin
      n_fail++; $display("FAIL prefetch_hold got ack=%b edn_req=%b required 0 0", ack_o, edn_req_o);
    end
    exp_q.push_back({1'b1, b});
    req_i = 1'b1;
    #1;
    n_checks++;
    if (ack_o !== 1'b1) begin n_fail++; $display("FAIL prefetch_ack got %b required 1", ack_o); end
    tick();
    req_i = 1'b0;
    tick();
  endtask

  task automatic test_proto(input logic [127:0] prev);
    logic [127:0] b = 128'h5A5A5A5A_A5A5A5A5_3C3C3C3C_C3C3C3C3;
    edn_ack_i = 1'b1; edn_bus_i = 32'hBAD0BAD0;
    #1;
    n_checks++;
    if (proto_err_o !== 1'b1) begin n_fail++; $display("FAIL proto_idle got %b required 1", proto_err_o); end
    tick();
    edn_ack_i = 1'b0;
    #1;
    n_checks++;
    if (proto_err_o !== 1'b0 || edn_req_o !== 1'b0 || data_o !== prev) begin
      n_fail++; $display("FAIL proto_idle_after got perr=%b edn_req=%b data=%h required 0 0 %h",
                         proto_err_o, edn_req_o, data_o, prev);
    end
    req_i = 1'b1;
    tick();
    req_i = 1'b0;
    deliver(b, 4'hF, 0);
    edn_ack_i = 1'b1; edn_bus_i = 32'hBAD1BAD1;
    #1;
    n_checks++;
    if (proto_err_o !== 1'b1) begin n_fail++; $display("FAIL proto_ready got %b required 1", proto_err_o); end
    tick();
    edn_ack_i = 1'b0;
    #1;
    n_checks++;
    if (data_o !== b || ack_o !== 1'b0) begin
      n_fail++; $display("FAIL proto_ready_hold got data=%h ack=%b required %h 0", data_o, ack_o, b);
    end
    exp_q.push_back({1'b1, b});
    req_i = 1'b1;
    tick();
    req_i = 1'b0;
    tick();
  endtask

  task automatic test_clear();
    logic [127:0] b  = 128'hDDDDDDDD_CCCCCCCC_BBBBBBBB_AAAAAAAA;
    logic [127:0] bx = 128'h99999999_88888888_77777777_66666666;
    req_i = 1'b1;
    tick();
    for (int i = 0; i < 2; i++) begin
      edn_ack_i = 1'b1; edn_bus_i = 32'h01010101 * (i + 1); edn_fips_i = 1'b1;
      tick();
    end
    clear_i = 1'b1; edn_bus_i = 32'hDEADBEEF;
    #1;
    n_checks++;
    if (proto_err_o !== 1'b0 || ack_o !== 1'b0) begin
      n_fail++; $display("FAIL clear_perr got perr=%b ack=%b required 0 0", proto_err_o, ack_o);
    end
    tick();
    clear_i = 1'b0; edn_ack_i = 1'b0;
    #1;
    n_checks++;
    if (edn_req_o !== 1'b0 || data_o !== 128'h0) begin
      n_fail++; $display("FAIL clear_idle got edn_req=%b data=%h required 0 0", edn_req_o, data_o);
    end
    tick();
    n_checks++;
    if (edn_req_o !== 1'b1) begin n_fail++; $display("FAIL clear_refill got %b required 1", edn_req_o); end
    exp_q.push_back({1'b1, b});
    deliver(b, 4'hF, 0);
    tick();
    tick();
    deliver(bx, 4'hF, 0);
    clear_i = 1'b1;
    #1;
    n_checks++;
    if (ack_o !== 1'b0 || fips_o !== 1'b0) begin
      n_fail++; $display("FAIL clear_ready_ack got ack=%b fips=%b required 0 0", ack_o, fips_o);
    end
    tick();
    clear_i = 1'b0; req_i = 1'b0;
    tick();
  endtask

  task automatic test_back_to_back();
    logic [127:0] e1, e2;
    int acks0;
    req_i = 1'b1;
    tick();
    edn_ack_i = 1'b1; edn_fips_i = 1'b1; edn_bus_i = 32'h11112222;
    tick();
    edn_ack_i = 1'b0;
    rst_ni = 1'b0;
    tick();
    rst_ni = 1'b1;
    #1;
    n_checks++;
    if ({ack_o, fips_o, edn_req_o, proto_err_o} !== 4'b0000 || data_o !== 128'h0) begin
      n_fail++; $display("FAIL reset_midfill got ack=%b fips=%b edn_req=%b perr=%b data=%h required all 0",
                         ack_o, fips_o, edn_req_o, proto_err_o, data_o);
    end
    for (int k = 1; k <= 4; k++) e1[(k-1)*32 +: 32] = 32'h50000000 + k;
    for (int k = 7; k <= 10; k++) e2[(k-7)*32 +: 32] = 32'h50000000 + k;
    exp_q.push_back({1'b1, e1});
    exp_q.push_back({1'b1, e2});
    acks0 = ack_cnt;
    edn_ack_i = 1'b1;
    for (int k = 0; k < 12; k++) begin
      edn_bus_i = 32'h50000000 + k;
      tick();
    end
    req_i = 1'b0; edn_ack_i = 1'b0;
    repeat (2) tick();
    n_checks++;
    if (ack_cnt - acks0 !== 2) begin n_fail++; $display("FAIL b2b_ack_count got %0d required 2", ack_cnt - acks0); end
    n_checks++;
    if (last_ack - prev_ack !== 6) begin n_fail++; $display("FAIL b2b_gap got %0d required 6", last_ack - prev_ack); end
  endtask

  initial begin
    logic [127:0] held;
    test_reset();
    test_basic();
    test_fips();
    test_prefetch(held);
    test_proto(held);
    test_clear();
    test_back_to_back();
    n_checks++;
    if (exp_q.size() != 0) begin
      n_fail++; $display("FAIL pending_bundles got %0d required 0", exp_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
